// File: rtl/dmem_responder.sv
// Single-port data memory that answers one load/store request at a time.
// A response appears a fixed LATENCY after acceptance and is held until taken.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t             state, state_nx;
  logic [3:0]         cnt;
  logic               cap_we;
  logic [31:0]        cap_addr;
  logic [31:0]        cap_wdata;
  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic               enter_resp;
  logic               eff_we;
  logic               eff_err;
  logic [31:0]        eff_addr;
  logic [31:0]        eff_wdata;
  logic [IDX_W-1:0]   eff_idx;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && reset;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  // With zero latency RESP is entered straight from IDLE, so the live request
  // is used instead of the not-yet-captured copy.
  assign enter_resp = reset && (state != RESP) && (state_nx == RESP);
  assign eff_we     = (state == IDLE) ? req_we    : cap_we;
  assign eff_addr   = (state == IDLE) ? req_addr  : cap_addr;
  assign eff_wdata  = (state == IDLE) ? req_wdata : cap_wdata;
  assign eff_idx    = eff_addr[IDX_W+1:2];
  assign eff_err    = addr_err(eff_addr);

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && eff_we && !eff_err) mem[eff_idx] <= eff_wdata;
  end

  // Response registers are loaded only on the edge entering RESP and then
  // hold for as long as the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      if (accept)                           cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        rsp_err   <= eff_err;
        rsp_rdata <= (!eff_we && !eff_err) ? mem[eff_idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance driven with
// directed vectors; a scoreboard monitor checks every response as it appears.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rv [2];
  logic        rr [2];
  logic        wev[2];
  logic        vv [2];
  logic        rsr[2];
  logic        er [2];
  logic        bs [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst_n), .req_valid(rv[0]), .req_ready(rr[0]),
    .req_we(wev[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
    .rsp_valid(vv[0]), .rsp_ready(rsr[0]), .rsp_rdata(rd[0]),
    .rsp_err(er[0]), .busy(bs[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(rst_n), .req_valid(rv[1]), .req_ready(rr[1]),
    .req_we(wev[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
    .rsp_valid(vv[1]), .rsp_ready(rsr[1]), .rsp_rdata(rd[1]),
    .rsp_err(er[1]), .busy(bs[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  vec_t v2[11] = '{
    '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0000_0064, 32'h0000_0000, 32'h0000_0007, 1'b0},
    '{1'b1, 32'h0000_0000, 32'h0000_0011, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 1'b1},
    '{1'b1, 32'h0000_0100, 32'h0000_FFFF, 32'h0000_0000, 1'b1},
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0011, 1'b0},
    '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0},
    '{1'b0, 32'h1000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
    '{1'b1, 32'h0000_0002, 32'h0000_0BAD, 32'h0000_0000, 1'b1},
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0011, 1'b0}
  };

  vec_t v0[4] = '{
    '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0},
    '{1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1},
    '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1}
  };

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat);
    int   n = 0;
    exp_t t;
    @(negedge clk);
    while (!rr[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rr[d]) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout dut=%0d got=0 expected=1", d);
      return;
    end
    rv[d] = 1'b1; wev[d] = w; ad[d] = a; wd[d] = dat;
    @(posedge clk);
    #1;
    t.rdata = exp_rd; t.err = exp_err; t.lat = lat; t.acc = cyc;
    if (d == 0) q0.push_back(t);
    else        q1.push_back(t);
    rv[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d);
    int n = 0;
    while (qsize(d) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (qsize(d) != 0) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout dut=%0d got=none expected=response", d);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  logic seen[2];
  exp_t cur [2];

  // Monitor: first valid cycle pops the scoreboard; later valid cycles check hold.
  initial begin
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!vv[d]) begin
          seen[d] = 1'b0;
        end else if (!seen[d]) begin
          seen[d] = 1'b1;
          if (qsize(d) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp dut=%0d got=valid expected=idle", d);
            cur[d].rdata = rd[d];
            cur[d].err   = er[d];
          end else begin
            cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("latency_d%0d", d), 32'(cyc - cur[d].acc), 32'(cur[d].lat));
            chk($sformatf("rdata_d%0d", d), rd[d], cur[d].rdata);
            chk($sformatf("err_d%0d", d), {31'd0, er[d]}, {31'd0, cur[d].err});
          end
        end else begin
          chk($sformatf("hold_rdata_d%0d", d), rd[d], cur[d].rdata);
          chk($sformatf("hold_err_d%0d", d), {31'd0, er[d]}, {31'd0, cur[d].err});
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_req_ready_d%0d", tag, d), {31'd0, rr[d]}, 32'd0);
      chk($sformatf("%s_rsp_valid_d%0d", tag, d), {31'd0, vv[d]}, 32'd0);
      chk($sformatf("%s_rsp_err_d%0d", tag, d), {31'd0, er[d]}, 32'd0);
      chk($sformatf("%s_rsp_rdata_d%0d", tag, d), rd[d], 32'd0);
      chk($sformatf("%s_busy_d%0d", tag, d), {31'd0, bs[d]}, 32'd0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; wev[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0; rsr[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset_d0", {31'd0, rr[0]}, 32'd1);
    chk("ready_after_reset_d1", {31'd0, rr[1]}, 32'd1);

    foreach (v2[i]) begin
      issue(0, v2[i].we, v2[i].addr, v2[i].wdata, v2[i].rdata, v2[i].err, 2);
      wait_rsp(0);
    end
    foreach (v0[i]) begin
      issue(1, v0[i].we, v0[i].addr, v0[i].wdata, v0[i].rdata, v0[i].err, 0);
      wait_rsp(1);
    end

    // Consumer stall with ignored request pulses
    rsr[0] = 1'b0;
    issue(0, 1'b0, 32'h64, 32'd0, 32'd7, 1'b0, 2);
    n = 0;
    while (!vv[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req_ready", {31'd0, rr[0]}, 32'd0);
      chk("stall_rsp_valid", {31'd0, vv[0]}, 32'd1);
      rv[0] = (i % 2 == 0); wev[0] = 1'b1; ad[0] = 32'h64; wd[0] = 32'h99;
    end
    @(negedge clk);
    rv[0] = 1'b0;
    rsr[0] = 1'b1;
    @(negedge clk);
    chk("post_stall_rsp_valid", {31'd0, vv[0]}, 32'd0);
    chk("post_stall_req_ready", {31'd0, rr[0]}, 32'd1);
    chk("post_stall_busy", {31'd0, bs[0]}, 32'd0);
    issue(0, 1'b0, 32'h64, 32'd0, 32'd7, 1'b0, 2);
    wait_rsp(0);

    // Reset abandons a store sitting in WAIT
    issue(0, 1'b1, 32'h8, 32'd3, 32'd0, 1'b0, 2);
    wait_rsp(0);
    issue(0, 1'b0, 32'h8, 32'd0, 32'd3, 1'b0, 2);
    wait_rsp(0);
    issue(0, 1'b1, 32'h8, 32'd5, 32'd0, 1'b0, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, rr[0]}, 32'd1);
    issue(0, 1'b0, 32'h8, 32'd0, 32'd3, 1'b0, 2);
    wait_rsp(0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
